// File: rtl/dual_port_pkg.sv
// Shared definitions for the banked, ECC-protected dual-port memory.
// Holds the parameter defaults, the Hamming SEC encode/decode functions and the address split helpers.
package dual_port_pkg;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_CODE_WIDTH    = 12;
  localparam int DEF_ADDR_WIDTH    = 5;
  localparam int DEF_WRITE_LATENCY = 4;
  localparam int DEF_READ_LATENCY  = 5;
  localparam int DEF_NUM_BANK      = 4;

  // The codec works on fixed maximum widths. Callers zero-extend their data and truncate the result.
  localparam int MAX_WIDTH  = 32;
  localparam int MAX_CODE   = 38;
  localparam int MAX_PARITY = 6;

  // The codeword uses positions 1..code_width. Parity bits sit at the power-of-two positions,
  // and data bits fill the remaining positions in ascending order.
  function automatic logic [MAX_CODE-1:0] ecc_encode(input logic [MAX_WIDTH-1:0] data,
                                                     input int code_width);
    logic [MAX_CODE-1:0] code;
    int d;
    // NOTE: blocking assignments are correct inside functions; each one is a combinational step.
    code = '0;
    d    = 0;
    for (int pos = 1; pos <= MAX_CODE; pos++) begin
      if (pos <= code_width && (pos & (pos - 1)) != 0) begin
        code[pos-1] = data[d];
        d++;
      end
    end
    for (int p = 0; p < MAX_PARITY; p++) begin
      logic par;
      par = 1'b0;
      for (int pos = 1; pos <= MAX_CODE; pos++)
        if (pos <= code_width && (pos & (1 << p)) != 0) par ^= code[pos-1];
      if ((1 << p) <= code_width) code[(1 << p) - 1] = par;
    end
    return code;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] ecc_decode(input logic [MAX_CODE-1:0] code_in,
                                                      input int code_width);
    logic [MAX_CODE-1:0]  code;
    logic [MAX_WIDTH-1:0] data;
    int syndrome;
    int d;
    code     = code_in;
    syndrome = 0;
    for (int p = 0; p < MAX_PARITY; p++) begin
      logic par;
      par = 1'b0;
      for (int pos = 1; pos <= MAX_CODE; pos++)
        if (pos <= code_width && (pos & (1 << p)) != 0) par ^= code[pos-1];
      if (par) syndrome |= (1 << p);
    end
    // A non-zero syndrome is the position of the single flipped bit.
    for (int pos = 1; pos <= MAX_CODE; pos++)
      if (pos == syndrome && pos <= code_width) code[pos-1] = ~code[pos-1];
    data = '0;
    d    = 0;
    for (int pos = 1; pos <= MAX_CODE; pos++) begin
      if (pos <= code_width && (pos & (pos - 1)) != 0) begin
        data[d] = code[pos-1];
        d++;
      end
    end
    return data;
  endfunction

  // The bank is taken from the high part of the wrapped address, and the row from the low part.
  function automatic int addr_bank(input int addr, input int depth, input int num_bank);
    return (addr % depth) / (depth / num_bank);
  endfunction

  function automatic int addr_row(input int addr, input int depth, input int num_bank);
    return (addr % depth) % (depth / num_bank);
  endfunction

endpackage

// File: rtl/dual_port_bank.sv
// One ECC-coded memory bank with two independent access ports.
// On a same-row write collision, port A wins. Reads return the contents stored before the current edge.
module dual_port_bank #(
  parameter int CODE_WIDTH = 12,
  parameter int ROWS       = 8,
  parameter int ROW_W      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we_a,
  input  logic [ROW_W-1:0]      i_wrow_a,
  input  logic [CODE_WIDTH-1:0] i_wcode_a,
  input  logic                  i_re_a,
  input  logic [ROW_W-1:0]      i_rrow_a,
  output logic [CODE_WIDTH-1:0] o_rcode_a,
  input  logic                  i_we_b,
  input  logic [ROW_W-1:0]      i_wrow_b,
  input  logic [CODE_WIDTH-1:0] i_wcode_b,
  input  logic                  i_re_b,
  input  logic [ROW_W-1:0]      i_rrow_b,
  output logic [CODE_WIDTH-1:0] o_rcode_b
);

  logic [ROWS-1:0][CODE_WIDTH-1:0] mem;

  // NOTE: the array must be cleared on reset, so it is built from flops rather than a RAM macro.
  // The codeword of zero data is all zeros.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem <= '0;
    end else begin
      if (i_we_b && !(i_we_a && i_wrow_a == i_wrow_b)) mem[i_wrow_b] <= i_wcode_b;
      if (i_we_a) mem[i_wrow_a] <= i_wcode_a;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_re_a) o_rcode_a <= mem[i_rrow_a];
    if (i_re_b) o_rcode_b <= mem[i_rrow_b];
  end

endmodule

// File: rtl/dual_port.sv
// Banked dual-port memory with Hamming SEC protection and fixed per-port write/read latencies.
// Each latency must be at least 2. Writes are not forwarded to reads that are still in flight.
module dual_port
  import dual_port_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int CODE_WIDTH      = DEF_CODE_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int WRITE_LATENCY_A = DEF_WRITE_LATENCY,
  parameter int WRITE_LATENCY_B = DEF_WRITE_LATENCY,
  parameter int READ_LATENCY_A  = DEF_READ_LATENCY,
  parameter int READ_LATENCY_B  = DEF_READ_LATENCY,
  parameter int NUM_BANK        = DEF_NUM_BANK,
  parameter int DEPTH           = 2 ** ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en_a,
  input  logic                  i_en_b,
  input  logic                  i_we_a,
  input  logic                  i_we_b,
  input  logic [WIDTH-1:0]      i_din_a,
  input  logic [WIDTH-1:0]      i_din_b,
  input  logic [ADDR_WIDTH-1:0] i_addr_a,
  input  logic [ADDR_WIDTH-1:0] i_addr_b,
  output logic [WIDTH-1:0]      o_dout_a1,
  output logic [WIDTH-1:0]      o_dout_b1
);

  localparam int ROWS   = DEPTH / NUM_BANK;
  localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Index 0 is port A and index 1 is port B.
  logic [1:0]            en, we, cm_vld, rd_req;
  logic [WIDTH-1:0]      din     [2];
  logic [ADDR_WIDTH-1:0] addr    [2];
  logic [BANK_W-1:0]     cm_bank [2];
  logic [BANK_W-1:0]     rd_bank [2];
  logic [ROW_W-1:0]      cm_row  [2];
  logic [ROW_W-1:0]      rd_row  [2];
  logic [CODE_WIDTH-1:0] cm_code [2];
  logic [WIDTH-1:0]      dout    [2];
  logic [CODE_WIDTH-1:0] bank_q  [2][NUM_BANK];

  assign en      = {i_en_b, i_en_a};
  assign we      = {i_we_b, i_we_a};
  assign din[0]  = i_din_a;
  assign din[1]  = i_din_b;
  assign addr[0] = i_addr_a;
  assign addr[1] = i_addr_b;

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int WL = (p == 0) ? WRITE_LATENCY_A : WRITE_LATENCY_B;
    localparam int RL = (p == 0) ? READ_LATENCY_A : READ_LATENCY_B;

    logic [BANK_W-1:0]     req_bank;
    logic [ROW_W-1:0]      req_row;
    logic                  wr_req;
    logic [WL-2:0]         w_vld;
    logic [BANK_W-1:0]     w_bank [WL-1];
    logic [ROW_W-1:0]      w_row  [WL-1];
    logic [CODE_WIDTH-1:0] w_code [WL-1];
    logic [RL-1:0]         r_vld;
    logic [BANK_W-1:0]     r_bank;
    logic [CODE_WIDTH-1:0] r_head;
    logic [CODE_WIDTH-1:0] r_code [RL-1];
    logic [WIDTH-1:0]      dout_q;

    assign req_bank  = BANK_W'(addr_bank(int'(addr[p]), DEPTH, NUM_BANK));
    assign req_row   = ROW_W'(addr_row(int'(addr[p]), DEPTH, NUM_BANK));
    assign wr_req    = en[p] & we[p];
    assign rd_req[p] = en[p] & ~we[p];
    assign rd_bank[p] = req_bank;
    assign rd_row[p]  = req_row;

    // Only the valid bits are flushed. Stale payload behind a cleared valid is never used.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        w_vld  <= '0;
        r_vld  <= '0;
        dout_q <= '0;
      end else begin
        w_vld[0] <= wr_req;
        for (int s = 1; s < WL - 1; s++) w_vld[s] <= w_vld[s-1];
        r_vld[0] <= rd_req[p];
        for (int s = 1; s < RL; s++) r_vld[s] <= r_vld[s-1];
        if (r_vld[RL-1]) dout_q <= WIDTH'(ecc_decode(MAX_CODE'(r_code[RL-2]), CODE_WIDTH));
      end
    end

    // NOTE: payload registers carry no reset; only the valid bits gate their use.
    always_ff @(posedge i_clk) begin
      w_bank[0] <= req_bank;
      w_row[0]  <= req_row;
      w_code[0] <= CODE_WIDTH'(ecc_encode(MAX_WIDTH'(din[p]), CODE_WIDTH));
      for (int s = 1; s < WL - 1; s++) begin
        w_bank[s] <= w_bank[s-1];
        w_row[s]  <= w_row[s-1];
        w_code[s] <= w_code[s-1];
      end
      r_bank    <= req_bank;
      r_code[0] <= r_head;
      for (int s = 1; s < RL - 1; s++) r_code[s] <= r_code[s-1];
    end

    // The bank registers the row one edge after issue, so select it using the bank captured at issue.
    assign r_head     = bank_q[p][r_bank];
    assign cm_vld[p]  = w_vld[WL-2];
    assign cm_bank[p] = w_bank[WL-2];
    assign cm_row[p]  = w_row[WL-2];
    assign cm_code[p] = w_code[WL-2];
    assign dout[p]    = dout_q;
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    dual_port_bank #(
      .CODE_WIDTH(CODE_WIDTH),
      .ROWS      (ROWS),
      .ROW_W     (ROW_W)
    ) u_bank (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_we_a   (cm_vld[0] && cm_bank[0] == BANK_W'(b)),
      .i_wrow_a (cm_row[0]),
      .i_wcode_a(cm_code[0]),
      .i_re_a   (rd_req[0] && rd_bank[0] == BANK_W'(b)),
      .i_rrow_a (rd_row[0]),
      .o_rcode_a(bank_q[0][b]),
      .i_we_b   (cm_vld[1] && cm_bank[1] == BANK_W'(b)),
      .i_wrow_b (cm_row[1]),
      .i_wcode_b(cm_code[1]),
      .i_re_b   (rd_req[1] && rd_bank[1] == BANK_W'(b)),
      .i_rrow_b (rd_row[1]),
      .o_rcode_b(bank_q[1][b])
    );
  end

  assign o_dout_a1 = dout[0];
  assign o_dout_b1 = dout[1];

endmodule

// File: tb/tb_dual_port.sv
// Self-checking bench for dual_port: directed vector table, ECC force test and randomized traffic
// compared against a queue-based model of commit/read timing.
module tb_dual_port;

  localparam int WL = 4;
  localparam int RL = 5;
  localparam int NV = 30;

  typedef struct packed {
    logic       en;
    logic       we;
    logic [4:0] addr;
    logic [7:0] din;
  } port_op_t;

  typedef struct {
    port_op_t   a;
    port_op_t   b;
    logic       rst;
    logic       chk_a;
    logic [7:0] exp_a;
    logic       chk_b;
    logic [7:0] exp_b;
  } vec_t;

  typedef struct { int due; logic [4:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int due; logic [7:0] data; } rd_t;

  logic       i_clk, i_rst, i_en_a, i_en_b, i_we_a, i_we_b;
  logic [7:0] i_din_a, i_din_b, o_dout_a1, o_dout_b1;
  logic [4:0] i_addr_a, i_addr_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem_m [32];
  wr_t wq_a[$], wq_b[$];
  rd_t rq_a[$], rq_b[$];
  logic [7:0] exp_a, exp_b;
  vec_t vec [NV];

  dual_port #(
    .WIDTH(8), .CODE_WIDTH(12), .ADDR_WIDTH(5),
    .WRITE_LATENCY_A(WL), .WRITE_LATENCY_B(WL),
    .READ_LATENCY_A(RL), .READ_LATENCY_B(RL),
    .NUM_BANK(4), .DEPTH(32)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_en_a(i_en_a), .i_en_b(i_en_b), .i_we_a(i_we_a), .i_we_b(i_we_b),
    .i_din_a(i_din_a), .i_din_b(i_din_b), .i_addr_a(i_addr_a), .i_addr_b(i_addr_b),
    .o_dout_a1(o_dout_a1), .o_dout_b1(o_dout_b1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic port_op_t idle();
    return '{en: 1'b0, we: 1'b0, addr: 5'd0, din: 8'h00};
  endfunction

  function automatic port_op_t wr(input int a, input logic [7:0] d);
    return '{en: 1'b1, we: 1'b1, addr: 5'(a), din: d};
  endfunction

  function automatic port_op_t rd(input int a);
    return '{en: 1'b1, we: 1'b0, addr: 5'(a), din: 8'h00};
  endfunction

  // An expected value of -1 means that port is not compared on that row.
  function automatic vec_t mk(input port_op_t a, input port_op_t b, input logic rst,
                              input int ea, input int eb);
    vec_t v;
    v.a = a;
    v.b = b;
    v.rst = rst;
    v.chk_a = (ea >= 0);
    v.exp_a = 8'(ea);
    v.chk_b = (eb >= 0);
    v.exp_b = 8'(eb);
    return v;
  endfunction

  function automatic port_op_t rand_op();
    port_op_t o;
    o.en   = ($urandom_range(0, 3) != 0);
    o.we   = ($urandom_range(0, 1) == 1);
    o.addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    o.din  = 8'($urandom);
    return o;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reads sample the array before this edge's commits. On a same-address commit, port A is applied last and wins.
  task automatic model_edge(input port_op_t a, input port_op_t b, input logic rst);
    if (rst) begin
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      wq_a.delete(); wq_b.delete(); rq_a.delete(); rq_b.delete();
      exp_a = 8'h00;
      exp_b = 8'h00;
    end else begin
      if (a.en && !a.we) rq_a.push_back('{cyc + RL, mem_m[a.addr]});
      if (b.en && !b.we) rq_b.push_back('{cyc + RL, mem_m[b.addr]});
      while (wq_b.size() > 0 && wq_b[0].due == cyc) begin
        mem_m[wq_b[0].addr] = wq_b[0].data;
        void'(wq_b.pop_front());
      end
      while (wq_a.size() > 0 && wq_a[0].due == cyc) begin
        mem_m[wq_a[0].addr] = wq_a[0].data;
        void'(wq_a.pop_front());
      end
      if (a.en && a.we) wq_a.push_back('{cyc + WL - 1, a.addr, a.din});
      if (b.en && b.we) wq_b.push_back('{cyc + WL - 1, b.addr, b.din});
      if (rq_a.size() > 0 && rq_a[0].due == cyc) begin
        exp_a = rq_a[0].data;
        void'(rq_a.pop_front());
      end
      if (rq_b.size() > 0 && rq_b[0].due == cyc) begin
        exp_b = rq_b[0].data;
        void'(rq_b.pop_front());
      end
    end
    cyc++;
  endtask

  task automatic step(input port_op_t a, input port_op_t b, input logic rst);
    i_rst    = rst;
    i_en_a   = a.en;  i_we_a = a.we;  i_addr_a = a.addr;  i_din_a = a.din;
    i_en_b   = b.en;  i_we_b = b.we;  i_addr_b = b.addr;  i_din_b = b.din;
    @(posedge i_clk);
    model_edge(a, b, rst);
    #1;
  endtask

  initial begin
    logic flip_bit;

    // Row index = edge number relative to the first row.
    for (int i = 0; i < NV; i++) vec[i] = mk(idle(), idle(), 1'b0, -1, -1);
    vec[0]  = mk(wr(3, 8'hA5), wr(0, 8'h01),  1'b0, 8'h00, 8'h00);
    vec[1]  = mk(wr(7, 8'h11), wr(8, 8'h02),  1'b0, -1, -1);
    vec[2]  = mk(idle(),       wr(16, 8'h03), 1'b0, -1, -1);
    vec[3]  = mk(rd(7),        wr(24, 8'h04), 1'b0, -1, -1);
    vec[4]  = mk(idle(),       rd(3),         1'b0, -1, -1);
    vec[5]  = mk(wr(10, 8'h3C), wr(10, 8'hC3), 1'b0, -1, -1);
    vec[8]  = mk(idle(), idle(), 1'b0, 8'h00, -1);
    vec[9]  = mk(idle(), rd(10), 1'b0, -1, 8'hA5);
    vec[10] = mk(rd(0),  idle(), 1'b0, -1, -1);
    vec[11] = mk(rd(8),  idle(), 1'b0, -1, -1);
    vec[12] = mk(rd(16), idle(), 1'b0, -1, -1);
    vec[13] = mk(rd(24), idle(), 1'b0, -1, -1);
    vec[14] = mk(idle(), idle(), 1'b0, -1, 8'h3C);
    vec[15] = mk(idle(), idle(), 1'b0, 8'h01, -1);
    vec[16] = mk(idle(), idle(), 1'b0, 8'h02, -1);
    vec[17] = mk(idle(), idle(), 1'b0, 8'h03, -1);
    vec[18] = mk(idle(), idle(), 1'b0, 8'h04, -1);
    vec[19] = mk(wr(31, 8'hFF), idle(), 1'b0, 8'h04, -1);
    vec[20] = mk(idle(), idle(), 1'b0, 8'h04, 8'h3C);
    vec[21] = mk(rd(3),  idle(), 1'b0, -1, -1);
    vec[23] = mk(wr(5, 8'h77), idle(), 1'b1, 8'h00, 8'h00);
    vec[24] = mk(rd(31), rd(5), 1'b0, -1, -1);
    vec[26] = mk(idle(), idle(), 1'b0, 8'h00, -1);
    vec[29] = mk(idle(), idle(), 1'b0, 8'h00, 8'h00);

    step(wr(1, 8'hEE), wr(2, 8'hDD), 1'b1);
    step(idle(), idle(), 1'b1);
    check("reset_a", o_dout_a1, 8'h00);
    check("reset_b", o_dout_b1, 8'h00);

    for (int i = 0; i < NV; i++) begin
      step(vec[i].a, vec[i].b, vec[i].rst);
      if (vec[i].chk_a) check($sformatf("vec%0d_a", i), o_dout_a1, vec[i].exp_a);
      if (vec[i].chk_b) check($sformatf("vec%0d_b", i), o_dout_b1, vec[i].exp_b);
    end

    // Single-bit codeword error: address 20 maps to bank 2, row 4.
    step(wr(20, 8'h5A), idle(), 1'b0);
    repeat (3) step(idle(), idle(), 1'b0);
    flip_bit = dut.g_bank[2].u_bank.mem[4][6];
    force dut.g_bank[2].u_bank.mem[4][6] = ~flip_bit;
    step(rd(20), idle(), 1'b0);
    release dut.g_bank[2].u_bank.mem[4][6];
    repeat (RL) step(idle(), idle(), 1'b0);
    check("ecc_correct", o_dout_a1, 8'h5A);

    for (int i = 0; i < 600; i++) begin
      step(rand_op(), rand_op(), ($urandom_range(0, 149) == 0));
      check("rand_a", o_dout_a1, exp_a);
      check("rand_b", o_dout_b1, exp_b);
    end
    repeat (RL + 1) begin
      step(idle(), idle(), 1'b0);
      check("drain_a", o_dout_a1, exp_a);
      check("drain_b", o_dout_b1, exp_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
